intc_bamse: RTL and testbench
=============================

Name: intc_bamse

Overview:
- PicoBlaze interrupt controller. It sits directly downstream of the timer and other port-mapped peripherals.
- It collects up to 8 interrupt lines (e.g. tmr_interrupt), latches rising edges into a pending register and applies a mask.
- It arbitrates by fixed priority and drives the single CPU interrupt/interrupt_ack handshake.
- Software reads the winning source ID and signals end-of-interrupt (EOI) over the same address/ren/wen port bus the timer uses.

Parameters:
- ADDR, 8'h10, base port address; the block decodes ADDR+0..ADDR+3.
- NSRC, 8, number of interrupt sources (1..8); unused upper bits read 0.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- irq_src  in  NSRC  peripheral interrupt lines, bit0 = highest priority (bit0 = timer).
- address  in  8  port address from PicoBlaze.
- data_in  in  8  write data (CPU out_port).
- data_out  out  8  read data; 8'h00 when not addressed, so it can be OR-combined.
- ren  in  1  read strobe.
- wen  in  1  write strobe.
- interrupt  out  1  interrupt request to PicoBlaze.
- interrupt_ack  in  1  acknowledge from PicoBlaze.
- busy  out  1  high while an interrupt is requested or in service.

Behaviour:
- Register map:
  - ADDR+0 MASK: RW, reset 8'h00.
  - ADDR+1 PENDING: R; write-1-to-clear.
  - ADDR+2 VECTOR: R = {busy, 4'b0, id[2:0]}; any write = EOI.
  - ADDR+3 CTRL: bit0 GIE (RW, reset 0); bit1 write-1 clears all pending (self-clearing, reads 0).
- Write decode: wen=1 and address==target, applied on the rising edge. Reads are combinational (data_out valid in the same cycle as address/ren).
- Edge detect:
  - irq_prev register resets to 0. pending[i] is set on the cycle after irq_src[i] goes 0->1.
  - A source held high through reset release produces one pending.
  - Level-high without a new edge never re-sets pending.
  - Pending sets regardless of MASK and GIE.
- Simultaneous edge set and W1C/clear-all on the same bit in the same cycle: set wins.
- Priority encoder: lowest index of (pending & mask).
- FSM IDLE / REQ / SERVICE (reset IDLE):
  - IDLE: if GIE and |(pending & mask), latch the encoder result into id, go to REQ. interrupt rises 1 cycle after the pending bit becomes visible.
  - REQ: interrupt=1 until interrupt_ack=1 is sampled. On ack: interrupt=0 next cycle, pending[id] cleared, go to SERVICE. Clearing MASK or GIE in REQ does not withdraw the request.
  - SERVICE: interrupt=0. On a write to VECTOR (EOI) go to IDLE. New edges keep accumulating in pending.
  - IDLE re-arbitrates one cycle after EOI. Minimum gap between interrupt pulses is 2 cycles.
- interrupt_ack outside REQ is ignored. EOI outside SERVICE is ignored.
- busy = (state != IDLE).
- Reset (rst=0) at any time, including mid-REQ:
  - MASK, PENDING, GIE, irq_prev, id and state go to 0/IDLE.
  - interrupt=0, busy=0, data_out=8'h00 (address not driven).
- NSRC<8: pending/mask bits at and above NSRC are tied 0. Writes to them are ignored.

Decomposition:
- Package intc_bamse_pkg:
  - register offset constants (OFS_MASK=0, OFS_PEND=1, OFS_VEC=2, OFS_CTRL=3);
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2);
  - CTRL bit indices.
- One sub-module: intc_prio_enc, a combinational NSRC-bit lowest-index-first encoder outputting a valid flag and a 3-bit id.

Test Plan:
1. Reset, then write MASK=8'h01 and CTRL=8'h01, then pulse irq_src[0] (timer) 0->1 -> PENDING reads 8'h01 next cycle; interrupt=1 one cycle later. Ack -> interrupt=0, PENDING=8'h00. VECTOR reads 8'h80. Write VECTOR -> busy=0.
2. MASK=8'h00, GIE=1, edge on irq_src[3] -> PENDING=8'h08 and interrupt stays 0. Then write MASK=8'h08 -> interrupt=1 within 2 cycles; VECTOR id=3.
3. Edges on bits 5 and 2 in the same cycle, MASK=8'hFF -> first VECTOR id=2. After ack+EOI, second interrupt with id=5. Interrupts are separated by at least 2 cycles.
4. Write PENDING=8'h04 in the same cycle as a new edge on bit 2 -> pending[2] remains 1 (set wins). Then CTRL=8'h03 -> PENDING=8'h00, GIE stays 1.
5. Drive rst=0 while interrupt=1 (in REQ) -> interrupt, busy, MASK, PENDING, CTRL all read 0 immediately and asynchronously. After release with irq_src[0] held high -> PENDING=8'h01.
6. Edge while in SERVICE -> interrupt stays 0 until EOI, then rises 2 cycles after the EOI write. An ack pulse while in IDLE has no effect.

Source files
------------

// File: rtl/intc_bamse_pkg.sv
// intc_bamse_pkg: register offsets, FSM states and CTRL bit positions
// shared by the interrupt controller and its priority encoder.
package intc_bamse_pkg;

   localparam logic [1:0] OFS_MASK = 2'd0;
   localparam logic [1:0] OFS_PEND = 2'd1;
   localparam logic [1:0] OFS_VEC  = 2'd2;
   localparam logic [1:0] OFS_CTRL = 2'd3;

   localparam int CTRL_GIE = 0;
   localparam int CTRL_CLR = 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

endpackage

// File: rtl/intc_bamse_prio.sv
// intc_prio_enc: lowest-index-first encoder over NSRC request bits.
// Ports: req in, valid (any bit set) out, id (winning index) out.
module intc_prio_enc #(
   parameter int NSRC = 8
) (
   input  logic [NSRC-1:0] req,
   output logic            valid,
   output logic [2:0]      id
);

   always_comb begin
      valid = |req;
      id    = 3'd0;
      // Scan downward so the lowest set index is the last assignment.
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req[i]) id = 3'(i);
      end
   end

endmodule

// File: rtl/intc_bamse.sv
// intc_bamse: 8-source edge-latched interrupt controller for PicoBlaze.
// Ports: clk, rst (async low), irq_src, port bus, interrupt/ack, busy.
module intc_bamse
   import intc_bamse_pkg::*;
#(
   parameter logic [7:0] ADDR = 8'h10,
   parameter int         NSRC = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] irq_src,
   input  logic [7:0]      address,
   input  logic [7:0]      data_in,
   output logic [7:0]      data_out,
   input  logic            ren,
   input  logic            wen,
   output logic            interrupt,
   input  logic            interrupt_ack,
   output logic            busy
);

   localparam logic [7:0] SRC_MSK = 8'((9'd1 << NSRC) - 9'd1);

   state_t     state_q, state_d;
   logic [7:0] mask_q, pend_q, prev_q;
   logic [7:0] irq_w, rise, active, ack_clr, clr;
   logic       gie_q;
   logic [2:0] id_q, id_d, enc_id;
   logic       enc_vld;
   logic [7:0] ofs;
   logic       hit;
   logic       wr_mask, wr_pend, wr_vec, wr_ctrl;

   always_comb begin
      irq_w = '0;
      irq_w[NSRC-1:0] = irq_src;
   end

   assign ofs     = address - ADDR;
   assign hit     = (ofs[7:2] == 6'd0);
   assign wr_mask = wen & hit & (ofs[1:0] == OFS_MASK);
   assign wr_pend = wen & hit & (ofs[1:0] == OFS_PEND);
   assign wr_vec  = wen & hit & (ofs[1:0] == OFS_VEC);
   assign wr_ctrl = wen & hit & (ofs[1:0] == OFS_CTRL);

   assign rise   = irq_w & ~prev_q;
   assign active = pend_q & mask_q;

   intc_prio_enc #(.NSRC(NSRC)) u_enc (
      .req   (active[NSRC-1:0]),
      .valid (enc_vld),
      .id    (enc_id)
   );

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      ack_clr = '0;
      unique case (state_q)
         IDLE: begin
            if (gie_q && enc_vld) begin
               state_d = REQ;
               id_d    = enc_id;
            end
         end
         REQ: begin
            if (interrupt_ack) begin
               state_d         = SERVICE;
               ack_clr[id_q]   = 1'b1;
            end
         end
         SERVICE: begin
            if (wr_vec) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      clr = ack_clr;
      if (wr_pend) clr = clr | data_in;
      if (wr_ctrl && data_in[CTRL_CLR]) clr = 8'hFF;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         id_q    <= 3'd0;
         mask_q  <= 8'h00;
         pend_q  <= 8'h00;
         prev_q  <= 8'h00;
         gie_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         prev_q  <= irq_w;
         // New edges are OR-ed in after clearing so a set always wins.
         pend_q  <= ((pend_q & ~clr) | rise) & SRC_MSK;
         if (wr_mask) mask_q <= data_in & SRC_MSK;
         if (wr_ctrl) gie_q  <= data_in[CTRL_GIE];
      end
   end

   assign interrupt = (state_q == REQ);
   assign busy      = (state_q != IDLE);

   always_comb begin
      data_out = 8'h00;
      if (ren && hit) begin
         unique case (ofs[1:0])
            OFS_MASK: data_out = mask_q;
            OFS_PEND: data_out = pend_q;
            OFS_VEC:  data_out = {busy, 4'b0000, id_q};
            OFS_CTRL: data_out = {7'b0000000, gie_q};
            default:  data_out = 8'h00;
         endcase
      end
   end

endmodule

// File: tb/tb_intc_bamse.sv
// tb_intc_bamse: directed bench with a behavioural model and
// per-cycle comparison of interrupt, busy and data_out.
module tb_intc_bamse;

   localparam logic [7:0] A = 8'h10;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] irq_src;
   logic [7:0] address;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       ren;
   logic       wen;
   logic       interrupt;
   logic       interrupt_ack;
   logic       busy;

   int n_chk  = 0;
   int n_fail = 0;

   intc_bamse #(.ADDR(A), .NSRC(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .irq_src       (irq_src),
      .address       (address),
      .data_in       (data_in),
      .data_out      (data_out),
      .ren           (ren),
      .wen           (wen),
      .interrupt     (interrupt),
      .interrupt_ack (interrupt_ack),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [7:0] got,
                        input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   // Behavioural model: mode 0 = waiting, 1 = requesting, 2 = serving.
   logic [7:0] m_mask, m_pend, m_prev;
   logic       m_gie;
   int         m_mode;
   logic [2:0] m_id;

   function automatic logic [2:0] first_set(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
      return 3'd0;
   endfunction

   function automatic logic [7:0] m_read(input logic [7:0] a);
      if (a == A)        return m_mask;
      if (a == A + 8'd1) return m_pend;
      if (a == A + 8'd2) return {(m_mode != 0), 4'b0000, m_id};
      if (a == A + 8'd3) return {7'b0000000, m_gie};
      return 8'h00;
   endfunction

   always @(posedge clk or negedge rst) begin : model
      logic [7:0] c;
      if (!rst) begin
         m_mask <= 8'h00;
         m_pend <= 8'h00;
         m_prev <= 8'h00;
         m_gie  <= 1'b0;
         m_mode <= 0;
         m_id   <= 3'd0;
      end else begin
         c = 8'h00;
         if (wen && address == A + 8'd1) c = c | data_in;
         if (wen && address == A + 8'd3 && data_in[1]) c = 8'hFF;
         if (m_mode == 0) begin
            if (m_gie && (m_pend & m_mask) != 8'h00) begin
               m_mode <= 1;
               m_id   <= first_set(m_pend & m_mask);
            end
         end else if (m_mode == 1) begin
            if (interrupt_ack) begin
               m_mode  <= 2;
               c[m_id] = 1'b1;
            end
         end else begin
            if (wen && address == A + 8'd2) m_mode <= 0;
         end
         m_pend <= (m_pend & ~c) | (irq_src & ~m_prev);
         m_prev <= irq_src;
         if (wen && address == A)        m_mask <= data_in;
         if (wen && address == A + 8'd3) m_gie  <= data_in[0];
      end
   end

   always @(negedge clk) begin
      check("cyc_interrupt", 8'(interrupt), 8'(m_mode == 1));
      check("cyc_busy", 8'(busy), 8'(m_mode != 0));
      check("cyc_data_out", data_out, ren ? m_read(address) : 8'h00);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      address = a;
      data_in = d;
      wen     = 1'b1;
      tick();
      wen     = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] exp,
                     input string nm);
      address = a;
      ren     = 1'b1;
      #1;
      check(nm, data_out, exp);
   endtask

   task automatic ack();
      interrupt_ack = 1'b1;
      tick();
      interrupt_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      irq_src = 8'h00;
      address = 8'h00;
      data_in = 8'h00;
      ren = 1'b0;
      wen = 1'b0;
      interrupt_ack = 1'b0;
      #1;
      check("rst_int", 8'(interrupt), 8'h00);
      check("rst_busy", 8'(busy), 8'h00);
      rd(A, 8'h00, "rst_mask");
      rd(A + 8'd1, 8'h00, "rst_pend");
      tick();
      rst = 1'b1;
      tick();

      // 1: timer source end to end
      wr(A, 8'h01);
      wr(A + 8'd3, 8'h01);
      irq_src = 8'h01;
      tick();
      rd(A + 8'd1, 8'h01, "t1_pend");
      check("t1_int_lo", 8'(interrupt), 8'h00);
      tick();
      check("t1_int_hi", 8'(interrupt), 8'h01);
      rd(A + 8'd2, 8'h80, "t1_vec_req");
      ack();
      check("t1_int_ack", 8'(interrupt), 8'h00);
      rd(A + 8'd1, 8'h00, "t1_pend_ack");
      rd(A + 8'd2, 8'h80, "t1_vec_srv");
      wr(A + 8'd2, 8'h00);
      check("t1_busy_eoi", 8'(busy), 8'h00);
      irq_src = 8'h00;
      tick();

      // 2: masked pending, then unmask
      wr(A, 8'h00);
      irq_src = 8'h08;
      tick();
      rd(A + 8'd1, 8'h08, "t2_pend");
      tick();
      tick();
      check("t2_int_masked", 8'(interrupt), 8'h00);
      wr(A, 8'h08);
      tick();
      check("t2_int_unmask", 8'(interrupt), 8'h01);
      rd(A + 8'd2, 8'h83, "t2_vec");
      ack();
      tick();
      rd(A + 8'd1, 8'h00, "t2_level_no_reset");
      wr(A + 8'd2, 8'h00);
      irq_src = 8'h00;
      tick();

      // 3: simultaneous edges, fixed priority
      wr(A, 8'hFF);
      irq_src = 8'h24;
      tick();
      tick();
      check("t3_int1", 8'(interrupt), 8'h01);
      rd(A + 8'd2, 8'h82, "t3_vec1");
      ack();
      check("t3_gap1", 8'(interrupt), 8'h00);
      rd(A + 8'd1, 8'h20, "t3_pend");
      wr(A + 8'd2, 8'h00);
      check("t3_gap2", 8'(interrupt), 8'h00);
      tick();
      check("t3_int2", 8'(interrupt), 8'h01);
      rd(A + 8'd2, 8'h85, "t3_vec2");
      ack();
      wr(A + 8'd2, 8'h00);
      irq_src = 8'h00;
      tick();

      // 4: W1C, set-wins, clear-all
      wr(A + 8'd3, 8'h00);
      irq_src = 8'h04;
      tick();
      irq_src = 8'h00;
      tick();
      rd(A + 8'd1, 8'h04, "t4_pend_set");
      wr(A + 8'd1, 8'h04);
      rd(A + 8'd1, 8'h00, "t4_w1c");
      irq_src = 8'h04;
      wr(A + 8'd1, 8'h04);
      rd(A + 8'd1, 8'h04, "t4_set_wins");
      wr(A + 8'd3, 8'h03);
      rd(A + 8'd1, 8'h00, "t4_clr_all");
      rd(A + 8'd3, 8'h01, "t4_ctrl");
      tick();
      check("t4_int", 8'(interrupt), 8'h00);
      irq_src = 8'h00;
      tick();

      // 5: async reset mid-request
      irq_src = 8'h01;
      tick();
      tick();
      check("t5_int_req", 8'(interrupt), 8'h01);
      rst = 1'b0;
      #1;
      check("t5_int_rst", 8'(interrupt), 8'h00);
      check("t5_busy_rst", 8'(busy), 8'h00);
      rd(A, 8'h00, "t5_mask_rst");
      rd(A + 8'd1, 8'h00, "t5_pend_rst");
      tick();
      rd(A + 8'd3, 8'h00, "t5_ctrl_rst");
      rst = 1'b1;
      tick();
      rd(A + 8'd1, 8'h01, "t5_pend_held");
      check("t5_int_post", 8'(interrupt), 8'h00);

      // 6: edge during service, ack in idle
      wr(A, 8'h01);
      wr(A + 8'd3, 8'h01);
      tick();
      check("t6_int1", 8'(interrupt), 8'h01);
      irq_src = 8'h00;
      ack();
      irq_src = 8'h01;
      tick();
      tick();
      check("t6_int_srv", 8'(interrupt), 8'h00);
      check("t6_busy_srv", 8'(busy), 8'h01);
      rd(A + 8'd1, 8'h01, "t6_pend_srv");
      wr(A + 8'd2, 8'h00);
      check("t6_int_eoi", 8'(interrupt), 8'h00);
      tick();
      check("t6_int2", 8'(interrupt), 8'h01);
      rd(A + 8'd2, 8'h80, "t6_vec");
      ack();
      wr(A + 8'd2, 8'h00);
      wr(A + 8'd3, 8'h00);
      irq_src = 8'h00;
      tick();
      irq_src = 8'h01;
      tick();
      ack();
      rd(A + 8'd1, 8'h01, "t6_ack_idle_pend");
      check("t6_ack_idle_busy", 8'(busy), 8'h00);
      rd(8'h20, 8'h00, "t6_unaddressed");
      address = A + 8'd1;
      ren = 1'b0;
      #1;
      check("t6_no_ren", data_out, 8'h00);
      tick();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
